// File: rtl/spike_rate_decoder.sv
// Rate decoder: counts spikes per channel over a programmable window and
// hands each window's counts to a valid/ready consumer.
module spike_rate_decoder #(
   parameter int NUM_INPUTS   = 1,
   parameter int COUNT_WIDTH  = 8,
   parameter int WINDOW_WIDTH = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              enable,
   input  logic [WINDOW_WIDTH-1:0]           window_len,
   input  logic [NUM_INPUTS-1:0]             spike_in,
   output logic [NUM_INPUTS*COUNT_WIDTH-1:0] count_out,
   output logic                              count_valid,
   input  logic                              count_ready,
   output logic                              busy,
   output logic                              overflow
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_COUNT = 1'b1;

   localparam logic [COUNT_WIDTH-1:0]  CNT_MAX = '1;
   localparam logic [WINDOW_WIDTH-1:0] WIN_ONE = WINDOW_WIDTH'(1);

   logic [0:0]                        r_state;
   logic [WINDOW_WIDTH-1:0]           r_remain;
   logic [NUM_INPUTS*COUNT_WIDTH-1:0] r_cnt;
   logic [NUM_INPUTS*COUNT_WIDTH-1:0] r_count_out;
   logic                              r_valid;
   logic                              r_overflow;

   logic [NUM_INPUTS*COUNT_WIDTH-1:0] w_next_cnt;
   logic [COUNT_WIDTH-1:0]            w_ch;
   logic [WINDOW_WIDTH-1:0]           w_load_len;
   logic                              w_final;
   logic                              w_accept;

   // Per-channel saturating increment; the counter sticks at all-ones.
   always_comb begin
      w_next_cnt = '0;
      w_ch       = '0;
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
         w_ch = r_cnt[i*COUNT_WIDTH +: COUNT_WIDTH];
         if (spike_in[i] && (w_ch != CNT_MAX)) begin
            w_ch = w_ch + 1'b1;
         end
         w_next_cnt[i*COUNT_WIDTH +: COUNT_WIDTH] = w_ch;
      end
   end

   assign w_load_len = (window_len == '0) ? WIN_ONE : window_len;
   assign w_final    = (r_state == S_COUNT) && (r_remain == WIN_ONE);
   assign w_accept   = !r_valid || count_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_remain <= '0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (enable) begin
                  r_remain <= w_load_len;
                  r_cnt    <= '0;
                  r_state  <= S_COUNT;
               end
            end
            S_COUNT: begin
               if (w_final) begin
                  // Back-to-back windows reload here so there is no idle gap.
                  if (enable) begin
                     r_remain <= w_load_len;
                     r_cnt    <= '0;
                  end else begin
                     r_remain <= '0;
                     r_cnt    <= w_next_cnt;
                     r_state  <= S_IDLE;
                  end
               end else begin
                  r_remain <= r_remain - 1'b1;
                  r_cnt    <= w_next_cnt;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // A finished window is published only into an empty or draining slot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count_out <= '0;
         r_valid     <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         if (w_final && w_accept) begin
            r_count_out <= w_next_cnt;
            r_valid     <= 1'b1;
         end else begin
            if (count_ready) begin
               r_valid <= 1'b0;
            end
            if (w_final) begin
               r_overflow <= 1'b1;
            end
         end
      end
   end

   assign count_out   = r_count_out;
   assign count_valid = r_valid;
   assign busy        = (r_state == S_COUNT);
   assign overflow    = r_overflow;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Randomized and directed bench for spike_rate_decoder, checked against a
// window-level reference model with unbounded sums clamped at publication.
module tb_spike_rate_decoder;

   localparam int N  = 2;
   localparam int CW = 8;
   localparam int WW = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              enable;
   logic [WW-1:0]     window_len;
   logic [N-1:0]      spike_in;
   logic [N*CW-1:0]   count_out;
   logic              count_valid;
   logic              count_ready;
   logic              busy;
   logic              overflow;

   spike_rate_decoder #(
      .NUM_INPUTS  (N),
      .COUNT_WIDTH (CW),
      .WINDOW_WIDTH(WW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .window_len (window_len),
      .spike_in   (spike_in),
      .count_out  (count_out),
      .count_valid(count_valid),
      .count_ready(count_ready),
      .busy       (busy),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   bit            m_active;
   bit            m_valid;
   bit            m_ovf;
   int            m_left;
   int            m_sum [N];
   logic [N*CW-1:0] m_out;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("count_out",   32'(count_out),   32'(m_out));
      chk("count_valid", 32'(count_valid), 32'(m_valid));
      chk("busy",        32'(busy),        32'(m_active));
      chk("overflow",    32'(overflow),    32'(m_ovf));
   endtask

   task automatic model_reset();
      m_active = 0;
      m_valid  = 0;
      m_ovf    = 0;
      m_left   = 0;
      m_out    = '0;
      for (int c = 0; c < N; c++) m_sum[c] = 0;
   endtask

   // One clock edge of behaviour, evaluated from the inputs held across it.
   task automatic model_edge();
      bit           written;
      logic [CW-1:0] clamped;
      int           maxv;
      written = 0;
      maxv    = (1 << CW) - 1;
      if (!m_active) begin
         if (enable) begin
            m_active = 1;
            m_left   = (window_len == 0) ? 1 : int'(window_len);
            for (int c = 0; c < N; c++) m_sum[c] = 0;
         end
      end else begin
         for (int c = 0; c < N; c++) m_sum[c] += int'(spike_in[c]);
         m_left--;
         if (m_left == 0) begin
            if (!m_valid || count_ready) begin
               for (int c = 0; c < N; c++) begin
                  clamped = CW'((m_sum[c] > maxv) ? maxv : m_sum[c]);
                  m_out[c*CW +: CW] = clamped;
               end
               written = 1;
            end else begin
               m_ovf = 1;
            end
            if (enable) begin
               m_left = (window_len == 0) ? 1 : int'(window_len);
               for (int c = 0; c < N; c++) m_sum[c] = 0;
            end else begin
               m_active = 0;
            end
         end
      end
      if (written) m_valid = 1;
      else if (count_ready) m_valid = 0;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   // Asynchronous reset: outputs must clear before any clock edge.
   task automatic do_reset();
      rst = 1'b0;
      model_reset();
      #1;
      check_outputs();
      #2;
      rst = 1'b1;
   endtask

   initial begin
      rst         = 1'b0;
      enable      = 1'b0;
      window_len  = '0;
      spike_in    = '0;
      count_ready = 1'b0;
      #1;
      do_reset();

      // Window of 4, continuous spikes on ch0, back-to-back windows.
      enable = 1'b1; window_len = 16'd4; spike_in = 2'b01; count_ready = 1'b1;
      for (int k = 0; k < 17; k++) step();
      chk("req028_out", 32'(count_out), 32'h0004);

      // Saturation over a 300-cycle window.
      do_reset();
      enable = 1'b1; window_len = 16'd300; spike_in = 2'b11; count_ready = 1'b1;
      step();
      enable = 1'b0;
      for (int k = 0; k < 300; k++) step();
      chk("req029_out", 32'(count_out), 32'h0000ffff);
      chk("req029_ovf", 32'(overflow), 32'h0);

      // Stalled consumer across three 2-cycle windows.
      do_reset();
      enable = 1'b1; window_len = 16'd2; spike_in = 2'b10; count_ready = 1'b0;
      for (int k = 0; k < 7; k++) step();
      chk("req030_out", 32'(count_out), 32'h0200);
      chk("req030_ovf", 32'(overflow), 32'h1);
      count_ready = 1'b1;
      enable      = 1'b0;
      for (int k = 0; k < 4; k++) step();

      // Two-channel pattern over a 5-cycle window.
      do_reset();
      enable = 1'b1; window_len = 16'd5; count_ready = 1'b1; spike_in = 2'b11;
      step();
      enable = 1'b0;
      for (int k = 0; k < 5; k++) begin
         spike_in = {1'b1, ((k % 2) == 0) ? 1'b1 : 1'b0};
         window_len = 16'(k + 7);
         step();
      end
      chk("req031_out", 32'(count_out), 32'h0503);
      step();

      // Reset in the middle of a 10-cycle window.
      do_reset();
      enable = 1'b1; window_len = 16'd10; spike_in = 2'b11; count_ready = 1'b1;
      step();
      step();
      enable = 1'b0;
      do_reset();
      for (int k = 0; k < 14; k++) step();

      // window_len of 0 gives one-cycle windows.
      do_reset();
      enable = 1'b1; window_len = '0; count_ready = 1'b1;
      step();
      for (int k = 0; k < 20; k++) begin
         spike_in = N'($urandom_range(0, 3));
         step();
      end

      // Free-running random traffic.
      do_reset();
      for (int k = 0; k < 2500; k++) begin
         enable      = ($urandom_range(0, 3) != 0);
         window_len  = WW'($urandom_range(0, 6));
         spike_in    = N'($urandom_range(0, 3));
         count_ready = ($urandom_range(0, 2) != 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
